// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-stall, load-use bubble and branch-flush
// steering for a 5-stage pipeline, with saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_pending,
    input  logic                 icache_resp,
    input  logic                 dmem_pending,
    input  logic                 dcache_resp,
    input  logic                 load_use,
    input  logic                 br_mispredict,
    output logic                 pc_load,
    output logic                 ifid_load,
    output logic                 idex_load,
    output logic                 exmem_load,
    output logic                 memwb_load,
    output logic                 ifid_rst,
    output logic                 idex_rst,
    output logic                 exmem_rst,
    output logic                 pc_redirect,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_i_done;
    logic                 r_d_done;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;

    logic w_i_ok;
    logic w_d_ok;
    logic w_mem_stall;
    logic w_adv;
    logic w_flush;
    logic w_bubble;

    // Done flags only carry meaning while stalled; they are cleared on every advance.
    assign w_i_ok      = !imem_pending | icache_resp | (r_i_done & (r_state == STALL));
    assign w_d_ok      = !dmem_pending | dcache_resp | (r_d_done & (r_state == STALL));
    assign w_mem_stall = !(w_i_ok & w_d_ok);

    // Gating with rst forces every control output low while reset is held.
    assign w_adv    = rst & !w_mem_stall;
    assign w_flush  = w_adv & br_mispredict;
    assign w_bubble = w_adv & load_use & !br_mispredict;

    assign pc_load     = w_adv & !w_bubble;
    assign ifid_load   = w_adv & !w_bubble;
    assign idex_load   = w_adv;
    assign exmem_load  = w_adv;
    assign memwb_load  = w_adv;
    assign ifid_rst    = w_flush;
    assign idex_rst    = w_flush | w_bubble;
    assign exmem_rst   = w_flush;
    assign pc_redirect = w_flush;

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign bubble_cnt = r_bubble_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_mem_stall) begin
                r_state <= STALL;
                // Retain responses that arrive on different cycles of one stall.
                if (icache_resp) r_i_done <= 1'b1;
                if (dcache_resp) r_d_done <= 1'b1;
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_state  <= RUN;
                r_i_done <= 1'b0;
                r_d_done <= 1'b0;
            end
            if (w_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            if (w_bubble && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl using a 4-bit counter
// instance so that saturation is reachable in a short run.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    // Output bundle order: pc, ifid, idex, exmem, memwb loads, ifid/idex/exmem rst, redirect
    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_ALL   = 9'b111110000;
    localparam logic [8:0] O_BUB   = 9'b001110100;
    localparam logic [8:0] O_FLUSH = 9'b111111111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          imem_pending = 1'b0;
    logic          icache_resp = 1'b0;
    logic          dmem_pending = 1'b0;
    logic          dcache_resp = 1'b0;
    logic          load_use = 1'b0;
    logic          br_mispredict = 1'b0;
    logic          pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic          ifid_rst, idex_rst, exmem_rst, pc_redirect;
    logic [CW-1:0] stall_cnt, flush_cnt, bubble_cnt;
    logic [8:0]    outs;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_pending (imem_pending),
        .icache_resp  (icache_resp),
        .dmem_pending (dmem_pending),
        .dcache_resp  (dcache_resp),
        .load_use     (load_use),
        .br_mispredict(br_mispredict),
        .pc_load      (pc_load),
        .ifid_load    (ifid_load),
        .idex_load    (idex_load),
        .exmem_load   (exmem_load),
        .memwb_load   (memwb_load),
        .ifid_rst     (ifid_rst),
        .idex_rst     (idex_rst),
        .exmem_rst    (exmem_rst),
        .pc_redirect  (pc_redirect),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                   ifid_rst, idex_rst, exmem_rst, pc_redirect};

    // Applies one cycle of inputs on the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic im, input logic ir, input logic dm,
                         input logic dr, input logic lu, input logic br);
        @(negedge clk);
        imem_pending  = im;
        icache_resp   = ir;
        dmem_pending  = dm;
        dcache_resp   = dr;
        load_use      = lu;
        br_mispredict = br;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_pending = 0; icache_resp = 0; dmem_pending = 0;
        dcache_resp = 0; load_use = 0; br_mispredict = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_pending = 0; dmem_pending = 0; load_use = 0; br_mispredict = 0;
        #1;
        n_vec++;
        if (outs !== O_NONE) begin
            n_err++;
            $display("FAIL reset_outs got=%b exp=%b", outs, O_NONE);
        end
        n_vec++;
        if ({stall_cnt, flush_cnt, bubble_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_cnts got=%h/%h/%h exp=0/0/0", stall_cnt, flush_cnt, bubble_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (outs !== O_ALL) begin
            n_err++;
            $display("FAIL reset_release got=%b exp=%b", outs, O_ALL);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_vec++;
            if (outs !== O_ALL) begin
                n_err++;
                $display("FAIL idle_c%0d got=%b exp=%b", c, outs, O_ALL);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({stall_cnt, flush_cnt, bubble_cnt} !== '0) begin
            n_err++;
            $display("FAIL idle_cnts got=%h/%h/%h exp=0/0/0", stall_cnt, flush_cnt, bubble_cnt);
        end
    endtask

    task automatic test_split();
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, c == 2, 1, c == 5, 0, 0);
            exp = (c == 5) ? O_ALL : O_NONE;
            n_vec++;
            if (outs !== exp) begin
                n_err++;
                $display("FAIL split_c%0d got=%b exp=%b", c, outs, exp);
            end
        end
        // A fresh icache request must stall again: i_done was cleared on the advance.
        drive(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (outs !== O_NONE) begin
            n_err++;
            $display("FAIL split_done_clear got=%b exp=%b", outs, O_NONE);
        end
        n_vec++;
        if (stall_cnt !== 4'd5) begin
            n_err++;
            $display("FAIL split_stall_cnt got=%0d exp=5", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 0, 0, 0, 1, 0);
        n_vec++;
        if (outs !== O_BUB) begin
            n_err++;
            $display("FAIL lu_outs got=%b exp=%b", outs, O_BUB);
        end
        drive(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (outs !== O_ALL) begin
            n_err++;
            $display("FAIL lu_after got=%b exp=%b", outs, O_ALL);
        end
        n_vec++;
        if (bubble_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL lu_cnts got=b%0d/f%0d exp=b1/f0", bubble_cnt, flush_cnt);
        end
    endtask

    task automatic test_mispredict_stall();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 1, c == 3, 0, 1);
            n_vec++;
            if (outs !== ((c == 3) ? O_FLUSH : O_NONE)) begin
                n_err++;
                $display("FAIL mp_stall_c%0d got=%b exp=%b", c, outs,
                         (c == 3) ? O_FLUSH : O_NONE);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (outs !== O_ALL) begin
            n_err++;
            $display("FAIL mp_after got=%b exp=%b", outs, O_ALL);
        end
        n_vec++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
            n_err++;
            $display("FAIL mp_cnts got=f%0d/s%0d exp=f1/s3", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mispredict_load_use();
        do_reset();
        drive(0, 0, 0, 0, 1, 1);
        n_vec++;
        if (outs !== O_FLUSH) begin
            n_err++;
            $display("FAIL mplu_outs got=%b exp=%b", outs, O_FLUSH);
        end
        drive(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (flush_cnt !== 4'd1 || bubble_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL mplu_cnts got=f%0d/b%0d exp=f1/b0", flush_cnt, bubble_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0);
        // Cycle 2: assert reset asynchronously while the stall is in progress.
        @(negedge clk);
        rst = 1'b0;
        dcache_resp = 1'b0;
        #1;
        n_vec++;
        if (outs !== O_NONE || stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL rms_outs got=%b/s%0d exp=%b/s0", outs, stall_cnt, O_NONE);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        n_vec++;
        if (outs !== O_NONE) begin
            n_err++;
            $display("FAIL rms_stale_done got=%b exp=%b", outs, O_NONE);
        end
        drive(0, 0, 1, 1, 0, 0);
        n_vec++;
        if (outs !== O_ALL) begin
            n_err++;
            $display("FAIL rms_resume got=%b exp=%b", outs, O_ALL);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < 15; c++) drive(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL sat_reach got=%0d exp=15", stall_cnt);
        end
        for (int c = 0; c < 3; c++) drive(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL sat_hold got=%0d exp=15", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_split();
        test_load_use();
        test_mispredict_stall();
        test_mispredict_load_use();
        test_reset_mid_stall();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
